alu_out_queue: RTL and testbench

- Parametrised successor to the ALU output-select stage.
- Selects one of NUM_OPS functional-unit results (data + carry) by opcode and captures it into a DEPTH-entry FIFO.
- Exposes captured results through a valid/ready handshake, so the ALU front end can issue back-to-back while the consumer (display/writeback) stalls.
- Flags out-of-range opcodes instead of silently ignoring them.

---
 rtl/alu_out_queue.sv | 118 +++++++++++
 tb/tb_alu_out_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_out_queue.sv
// Opcode-selected ALU result capture into a DEPTH-entry valid/ready FIFO.
// Optional zero/negative flags per entry when ALU_OUT_FLAGS_EN is defined.
module alu_out_queue #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_OPS = 8,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SEL_W-1:0]           s,
  input  logic [NUM_OPS*WIDTH-1:0]   op_d,
  input  logic [NUM_OPS-1:0]         op_cout,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           d,
  output logic                       cout,
`ifdef ALU_OUT_FLAGS_EN
  output logic                       zf,
  output logic                       nf,
`endif
  output logic                       sel_err,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
`ifdef ALU_OUT_FLAGS_EN
  localparam int unsigned EntryW = WIDTH + 3;
`else
  localparam int unsigned EntryW = WIDTH + 1;
`endif
  localparam logic [SEL_W:0] NumOpsL = (SEL_W + 1)'(NUM_OPS);
  localparam logic [CntW-1:0] DepthL = CntW'(DEPTH);

  logic [EntryW-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              r_sel_err;

  logic              w_accept;
  logic              w_legal;
  logic              w_push;
  logic              w_pop;
  logic              w_illegal;
  logic [WIDTH-1:0]  w_sel_d;
  logic              w_sel_c;
  logic [EntryW-1:0] w_entry;
  logic [EntryW-1:0] w_head;

  assign in_ready  = (r_count != DepthL);
  assign out_valid = (r_count != '0);
  assign w_accept  = in_valid && in_ready;
  assign w_legal   = ({1'b0, s} < NumOpsL);
  assign w_push    = w_accept && w_legal;
  assign w_illegal = w_accept && !w_legal;
  assign w_pop     = out_valid && out_ready;

  // Loop mux keeps out-of-range opcodes from indexing past op_d.
  always_comb begin
    w_sel_d = '0;
    w_sel_c = 1'b0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (s == SEL_W'(k)) begin
        w_sel_d = op_d[k*WIDTH +: WIDTH];
        w_sel_c = op_cout[k];
      end
    end
  end

`ifdef ALU_OUT_FLAGS_EN
  assign w_entry = {(w_sel_d == '0), w_sel_d[WIDTH-1], w_sel_c, w_sel_d};
`else
  assign w_entry = {w_sel_c, w_sel_d};
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_illegal;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign w_head  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign d       = w_head[WIDTH-1:0];
  assign cout    = w_head[WIDTH];
`ifdef ALU_OUT_FLAGS_EN
  assign nf      = w_head[WIDTH+1];
  assign zf      = w_head[WIDTH+2];
`endif
  assign sel_err = r_sel_err;
  assign level   = r_count;

endmodule

// File: tb/tb_alu_out_queue.sv
// Directed self-checking bench for alu_out_queue (NUM_OPS=6 so opcodes 6/7 are illegal).
// Flag checks are compiled in when ALU_OUT_FLAGS_EN is defined.
module tb_alu_out_queue;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned NUM_OPS = 6;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned DEPTH   = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [SEL_W-1:0]         s;
  logic [NUM_OPS*WIDTH-1:0] op_d;
  logic [NUM_OPS-1:0]       op_cout;
  logic                     in_valid;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         d;
  logic                     cout;
  logic                     sel_err;
  logic [2:0]               level;
`ifdef ALU_OUT_FLAGS_EN
  logic                     zf;
  logic                     nf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  alu_out_queue #(
    .WIDTH  (WIDTH),
    .NUM_OPS(NUM_OPS),
    .SEL_W  (SEL_W),
    .DEPTH  (DEPTH)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (s),
    .op_d     (op_d),
    .op_cout  (op_cout),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d        (d),
    .cout     (cout),
`ifdef ALU_OUT_FLAGS_EN
    .zf       (zf),
    .nf       (nf),
`endif
    .sel_err  (sel_err),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic [7:0] val, input logic c);
    op_d          = '0;
    op_cout       = '0;
    s             = SEL_W'(ch);
    if (ch < NUM_OPS) begin
      op_d[ch*WIDTH +: WIDTH] = val;
      op_cout[ch]             = c;
    end
    in_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; s = '0; op_d = '0; op_cout = '0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_level", 32'(level), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_d", 32'(d), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_sel_err", 32'(sel_err), 0);
    rst_n = 1'b1;
    step();

    // Single push, hold, then pop.
    drive(1, 8'h3C, 1'b1);
    step();
    in_valid = 1'b0;
    check("single_valid", 32'(out_valid), 1);
    check("single_d", 32'(d), 32'h3C);
    check("single_cout", 32'(cout), 1);
    check("single_level", 32'(level), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_d", 32'(d), 32'h3C);
      check("hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pop_valid", 32'(out_valid), 0);
    check("pop_d", 32'(d), 0);
    check("pop_level", 32'(level), 0);

    // Fill to DEPTH, overflow attempt, illegal opcode while full, drain.
    for (int i = 1; i <= 4; i++) begin
      drive(0, 8'(i), 1'b0);
      step();
    end
    check("full_in_ready", 32'(in_ready), 0);
    check("full_level", 32'(level), 4);
    drive(0, 8'h05, 1'b0);
    step();
    check("overflow_level", 32'(level), 4);
    drive(7, 8'h00, 1'b0);
    step();
    check("full_no_sel_err", 32'(sel_err), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_d", 32'(d), 32'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 0);

    // Streaming push+pop, pointers wrap.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(0, 8'hA0 + 8'(i), 1'b0);
      step();
      check("stream_level", 32'(level), 1);
      check("stream_d", 32'(d), 32'hA0 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("stream_end_level", 32'(level), 0);

    // Illegal opcodes 7 and 6.
    drive(7, 8'h00, 1'b0);
    step();
    in_valid = 1'b0;
    check("illegal7_sel_err", 32'(sel_err), 1);
    check("illegal7_level", 32'(level), 0);
    check("illegal7_valid", 32'(out_valid), 0);
    step();
    check("illegal7_pulse_end", 32'(sel_err), 0);
    drive(6, 8'h00, 1'b0);
    step();
    in_valid = 1'b0;
    check("illegal6_sel_err", 32'(sel_err), 1);
    step();
    check("illegal6_pulse_end", 32'(sel_err), 0);
    drive(5, 8'h77, 1'b1);
    step();
    in_valid  = 1'b0;
    check("ch5_d", 32'(d), 32'h77);
    check("ch5_sel_err", 32'(sel_err), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset mid-stream.
    drive(2, 8'h11, 1'b0); step();
    drive(2, 8'h22, 1'b0); step();
    drive(2, 8'h33, 1'b0); step();
    in_valid = 1'b0;
    check("pre_rst_level", 32'(level), 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_level", 32'(level), 0);
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_d", 32'(d), 0);
    #1 rst_n = 1'b1;
    step();
    drive(3, 8'h5A, 1'b0);
    step();
    in_valid = 1'b0;
    check("post_rst_d", 32'(d), 32'h5A);
    check("post_rst_level", 32'(level), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

`ifdef ALU_OUT_FLAGS_EN
    drive(0, 8'h00, 1'b0); step();
    drive(0, 8'h80, 1'b0); step();
    in_valid = 1'b0;
    check("flags0_zf", 32'(zf), 1);
    check("flags0_nf", 32'(nf), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("flags80_zf", 32'(zf), 0);
    check("flags80_nf", 32'(nf), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("flags_empty_zf", 32'(zf), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
